// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the MIPS instruction-fetch stage:
//   if_state_e  : fetch FSM state encodings (IF_REQ, IF_WAIT, IF_HOLD)
//   IF_RESET_PC : default PC loaded on reset
//   IF_NOP      : instruction word presented by an empty IF/ID register
// ---------------------------------------------------------------------------
package if_stage_pkg;

   typedef enum logic [1:0] {
      IF_REQ  = 2'd0,
      IF_WAIT = 2'd1,
      IF_HOLD = 2'd2
   } if_state_e;

   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_NOP      = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Instruction-memory fetch bus: one outstanding request, req/ack accept
// handshake followed by a separate rvalid data return.
//   inst_req    : fetch request (held stable until inst_ack)
//   inst_addr   : fetch address
//   inst_ack    : memory accepted the request
//   inst_rvalid : read data valid, at least one cycle after inst_ack
//   inst_rdata  : fetched word
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_stage_if #(
   parameter int PC_W = 32
) ();

   logic            inst_req;
   logic [PC_W-1:0] inst_addr;
   logic            inst_ack;
   logic            inst_rvalid;
   logic [31:0]     inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_ack,
      input  inst_rvalid,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_ack,
      output inst_rvalid,
      output inst_rdata
   );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register {valid, instr, pc, pc_plus4}.
//   clk, rst     : clock, synchronous active-high reset (clears everything)
//   i_load       : capture a new instruction (highest priority after rst)
//   i_clear      : no load and decode not stalled -> insert a bubble
//   i_instr/i_pc/i_pc_plus4 : data captured on i_load
//   o_valid/o_instr/o_pc/o_pc_plus4 : register contents
// With neither i_load nor i_clear the whole register holds (decode stall).
// A bubble only drops valid; the payload keeps its last value.
// ---------------------------------------------------------------------------
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [31:0]     i_instr,
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_pc_plus4,
   output logic            o_valid,
   output logic [31:0]     o_instr,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_plus4
);

   logic            r_valid;
   logic [31:0]     r_instr;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pc_plus4;

   // IF/ID register: reset > load > bubble > hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_instr    <= IF_NOP;
         r_pc       <= {PC_W{1'b0}};
         r_pc_plus4 <= {PC_W{1'b0}};
      end else if (i_load) begin
         r_valid    <= 1'b1;
         r_instr    <= i_instr;
         r_pc       <= i_pc;
         r_pc_plus4 <= i_pc_plus4;
      end else if (i_clear) begin
         r_valid    <= 1'b0;
      end else begin
         r_valid    <= r_valid;
      end
   end

   assign o_valid    = r_valid;
   assign o_instr    = r_instr;
   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the fetch PC,
// issues one outstanding fetch at a time and feeds the IF/ID register.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   i_stall_d          : decode stalled, IF/ID must hold
//   i_redirect_valid   : taken branch/jump in decode (only while not stalled)
//   i_redirect_pc      : redirect target
//   mem                : instruction fetch bus (if_stage_if.master)
//   o_valid_d, o_instr_d, o_pc_d, o_pc_plus4_d : IF/ID register
// Configuration macro IF_BRANCH_DELAY_SLOT_EN:
//   undefined : the fetch after a redirecting branch is squashed
//   defined   : that fetch is the delay slot and is delivered normally
// ---------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(IF_RESET_PC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall_d,
   input  logic             i_redirect_valid,
   input  logic [PC_W-1:0]  i_redirect_pc,
   if_stage_if.master       mem,
   output logic             o_valid_d,
   output logic [31:0]      o_instr_d,
   output logic [PC_W-1:0]  o_pc_d,
   output logic [PC_W-1:0]  o_pc_plus4_d
);

`ifdef IF_BRANCH_DELAY_SLOT_EN
   localparam logic SQUASH = 1'b0;
`else
   localparam logic SQUASH = 1'b1;
`endif

   if_state_e       r_state;
   if_state_e       w_state_nxt;
   logic [PC_W-1:0] r_pc_f;
   logic [PC_W-1:0] w_pc_nxt;
   logic            r_drop;
   logic            w_drop_nxt;
   logic            r_redir_pend;
   logic            w_pend_nxt;
   logic [PC_W-1:0] r_redir_tgt;
   logic [PC_W-1:0] w_tgt_nxt;
   logic [31:0]     r_hold_instr;
   logic [31:0]     w_hold_nxt;

   logic            w_req;
   logic            w_load;
   logic [31:0]     w_load_instr;
   logic [PC_W-1:0] w_pc_plus4_f;
   logic [PC_W-1:0] w_next_pc;
   logic            w_valid_d;
   logic            w_if_id_free;

   // Sequential PC wraps modulo 2^PC_W; a pending redirect overrides it
   assign w_pc_plus4_f = r_pc_f + PC_W'(4);
   assign w_next_pc    = r_redir_pend ? r_redir_tgt : w_pc_plus4_f;
   assign w_if_id_free = ~i_stall_d | ~w_valid_d;

   // Fetch FSM state and PC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IF_REQ;
         r_pc_f       <= RESET_PC;
         r_drop       <= 1'b0;
         r_redir_pend <= 1'b0;
         r_redir_tgt  <= {PC_W{1'b0}};
         r_hold_instr <= IF_NOP;
      end else begin
         r_state      <= w_state_nxt;
         r_pc_f       <= w_pc_nxt;
         r_drop       <= w_drop_nxt;
         r_redir_pend <= w_pend_nxt;
         r_redir_tgt  <= w_tgt_nxt;
         r_hold_instr <= w_hold_nxt;
      end
   end

   // Fetch FSM next-state, PC update and IF/ID load control
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc_f;
      w_drop_nxt   = r_drop;
      w_pend_nxt   = r_redir_pend;
      w_tgt_nxt    = r_redir_tgt;
      w_hold_nxt   = r_hold_instr;
      w_load       = 1'b0;
      w_load_instr = mem.inst_rdata;
      w_req        = 1'b0;
      case (r_state)
         IF_REQ: begin
            // Request and address stay put until accepted, even on redirect
            w_req = 1'b1;
            if (mem.inst_ack) begin
               w_state_nxt = IF_WAIT;
            end else begin
               w_state_nxt = IF_REQ;
            end
            if (i_redirect_valid) begin
               w_drop_nxt = SQUASH;
               w_pend_nxt = 1'b1;
               w_tgt_nxt  = i_redirect_pc;
            end else begin
               w_pend_nxt = r_redir_pend;
            end
         end
         IF_WAIT: begin
            if (mem.inst_rvalid) begin
               if (r_drop || (SQUASH && i_redirect_valid)) begin
                  // Squashed fetch: discard the word and go to the target
                  w_pc_nxt    = i_redirect_valid ? i_redirect_pc : w_next_pc;
                  w_drop_nxt  = 1'b0;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = IF_REQ;
               end else if (w_if_id_free) begin
                  w_load      = 1'b1;
                  w_pc_nxt    = i_redirect_valid ? i_redirect_pc : w_next_pc;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = IF_REQ;
               end else begin
                  w_hold_nxt  = mem.inst_rdata;
                  w_state_nxt = IF_HOLD;
               end
            end else if (i_redirect_valid) begin
               w_drop_nxt = SQUASH;
               w_pend_nxt = 1'b1;
               w_tgt_nxt  = i_redirect_pc;
            end else begin
               w_state_nxt = IF_WAIT;
            end
         end
         IF_HOLD: begin
            if (SQUASH && i_redirect_valid) begin
               w_pc_nxt    = i_redirect_pc;
               w_drop_nxt  = 1'b0;
               w_pend_nxt  = 1'b0;
               w_state_nxt = IF_REQ;
            end else if (!i_stall_d) begin
               w_load       = 1'b1;
               w_load_instr = r_hold_instr;
               w_pc_nxt     = i_redirect_valid ? i_redirect_pc : w_next_pc;
               w_pend_nxt   = 1'b0;
               w_state_nxt  = IF_REQ;
            end else begin
               w_state_nxt = IF_HOLD;
            end
         end
         default: begin
            w_state_nxt = IF_REQ;
         end
      endcase
   end

   // No request is shown while reset is being applied
   assign mem.inst_req  = w_req & ~rst;
   assign mem.inst_addr = r_pc_f;

   if_id_reg #(
      .PC_W (PC_W)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_clear    (~i_stall_d),
      .i_instr    (w_load_instr),
      .i_pc       (r_pc_f),
      .i_pc_plus4 (w_pc_plus4_f),
      .o_valid    (w_valid_d),
      .o_instr    (o_instr_d),
      .o_pc       (o_pc_d),
      .o_pc_plus4 (o_pc_plus4_d)
   );

   assign o_valid_d = w_valid_d;

endmodule
